// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption engine: one full round per clock with on-the-fly key expansion,
// valid/ready handshakes on the plaintext and ciphertext sides.
module aes_enc_iter #(
  parameter bit ZERO_OUT_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table constant.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;

  logic [127:0] sb, sr, mc, rk_next, round_out;
  logic [31:0]  w0n, w1n, w2n, w3n, rot_sub;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    // Row r of output column c takes row r of input column (c+r)%4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
    rot_sub = {sbox(rk_q[23:16]), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
    w0n = rk_q[127:96] ^ rot_sub ^ {rcon(round_q), 24'h0};
    w1n = rk_q[95:64] ^ w0n;
    w2n = rk_q[63:32] ^ w1n;
    w3n = rk_q[31:0] ^ w2n;
    rk_next = {w0n, w1n, w2n, w3n};
    round_out = ((round_q == 4'd10) ? sr : mc) ^ rk_next;
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    rk_d    = rk_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (round_q == 4'd0 || round_q > 4'd10) begin
          round_d = 4'd0;
          fsm_d   = IDLE;
        end else begin
          state_d = round_out;
          rk_d    = rk_next;
          round_d = round_q + 4'd1;
          if (round_q == 4'd10) fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          round_d = 4'd0;
          fsm_d   = IDLE;
        end
      end
      default: begin
        round_d = 4'd0;
        fsm_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      rk_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      rk_q    <= rk_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q != IDLE);
  assign ciphertext = (ZERO_OUT_IDLE && !out_valid) ? '0 : state_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Scoreboard bench for aes_enc_iter: directed FIPS-197 vectors, backpressure,
// back-to-back accepts and mid-operation reset.
module tb_aes_enc_iter;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cycle = 0;
  logic [127:0] exp_q[$];

  aes_enc_iter #(.ZERO_OUT_IDLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: each negedge with out_valid && out_ready precedes exactly one transfer edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_output: got %h, expected no output", ciphertext);
        end else begin
          checkOutput("ciphertext", ciphertext, exp_q.pop_front());
        end
      end
      if (!out_valid) checkOutput("zero_when_idle", ciphertext, 128'h0);
    end
  end

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] expct, input bit hold, output int acc);
    int n;
    n = 0;
    plaintext = pt;
    key = k;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 128'(in_ready), 128'h1);
    @(posedge clk);
    exp_q.push_back(expct);
    #1;
    acc = cycle;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 128'(exp_q.size()), 128'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc1, acc2, lat, held_bad;

    // Reset state
    #1;
    checkOutput("reset_out_valid", 128'(out_valid), 128'h0);
    checkOutput("reset_busy", 128'(busy), 128'h0);
    checkOutput("reset_ciphertext", ciphertext, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", 128'(in_ready), 128'h1);

    // FIPS-197 C.1 with latency check and in_valid pulsed while busy
    out_ready = 1'b1;
    applyStimulus(PT1, KEY1, CT1, 1'b0, acc1);
    repeat (3) @(posedge clk);
    #1;
    plaintext = PT2;
    key = KEY2;
    in_valid = 1'b1;
    checkOutput("busy_in_ready", 128'(in_ready), 128'h0);
    checkOutput("busy_flag", 128'(busy), 128'h1);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitValid(lat);
    checkOutput("latency_c1", 128'(lat + 6), 128'd10);
    @(posedge clk);
    #1;
    checkOutput("idle_after_xfer", 128'(in_ready), 128'h1);
    checkOutput("valid_after_xfer", 128'(out_valid), 128'h0);
    waitDrain();

    // FIPS-197 App.B
    applyStimulus(PT2, KEY2, CT2, 1'b0, acc1);
    waitValid(lat);
    checkOutput("latency_b", 128'(lat), 128'd10);
    waitDrain();

    // Backpressure for 20 clocks
    out_ready = 1'b0;
    applyStimulus(PT2, KEY2, CT2, 1'b0, acc1);
    waitValid(lat);
    checkOutput("latency_bp", 128'(lat), 128'd10);
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || !busy || ciphertext !== CT2) held_bad++;
    end
    checkOutput("backpressure_hold", 128'(held_bad), 128'h0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_in_ready", 128'(in_ready), 128'h1);
    checkOutput("bp_release_valid", 128'(out_valid), 128'h0);
    waitDrain();

    // Back-to-back accepts with in_valid held
    applyStimulus(PT1, KEY1, CT1, 1'b1, acc1);
    applyStimulus(PT2, KEY2, CT2, 1'b0, acc2);
    checkOutput("accept_spacing", 128'(acc2 - acc1), 128'd12);
    waitDrain();

    // Reset in the middle of round 5
    applyStimulus(PT1, KEY1, CT1, 1'b0, acc1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midreset_busy", 128'(busy), 128'h0);
    checkOutput("midreset_valid", 128'(out_valid), 128'h0);
    checkOutput("midreset_ciphertext", ciphertext, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    held_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) held_bad++;
    end
    checkOutput("no_stale_output", 128'(held_bad), 128'h0);
    applyStimulus(PT1, KEY1, CT1, 1'b0, acc1);
    waitValid(lat);
    checkOutput("latency_after_reset", 128'(lat), 128'd10);
    waitDrain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
